// File: rtl/alu_logic_pkg.sv
// Shared types for the two-requester logic-unit arbiter: op codes, FSM states, default width.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package alu_logic_pkg;

    localparam int DEF_W = 4;

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_NAND  = 3'b001,
        OP_OR    = 3'b010,
        OP_NOR   = 3'b011,
        OP_XOR   = 3'b100,
        OP_XNOR  = 3'b101,
        OP_NOTA  = 3'b110,
        OP_PASSA = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/alu_logic_unit.sv
// Combinational 4-bit logic unit; result zero-extended to 2*W bits.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module alu_logic_unit
    import alu_logic_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    input  alu_op_e        op_i,
    output logic [2*W-1:0] r_o
);

    logic [W-1:0] r;

    // Op decode; the upper half of the result is always zero.
    always_comb begin
        r = '0;
        case (op_i)
            OP_AND:   r = a_i & b_i;
            OP_NAND:  r = ~(a_i & b_i);
            OP_OR:    r = a_i | b_i;
            OP_NOR:   r = ~(a_i | b_i);
            OP_XOR:   r = a_i ^ b_i;
            OP_XNOR:  r = ~(a_i ^ b_i);
            OP_NOTA:  r = ~a_i;
            OP_PASSA: r = a_i;
            default:  r = '0;
        endcase
        r_o = {{W{1'b0}}, r};
    end

endmodule

// File: rtl/alu_logic_arbiter.sv
// Round-robin share of one logic unit between two requesters; optional grant counters under ALU_ARB_STATS_EN.
// Latency: accept at edge N, res_valid high after edge N+1; one result per 3 cycles at best.
// Backpressure: response held in RESP until res_ready; req*_ready only pulses in IDLE, so pending requests wait.
module alu_logic_arbiter
    import alu_logic_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [W-1:0]   req0_a,
    input  logic [W-1:0]   req0_b,
    input  logic [2:0]     req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [W-1:0]   req1_a,
    input  logic [W-1:0]   req1_b,
    input  logic [2:0]     req1_op,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_data,
    output logic           res_id
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [7:0]     grant_cnt0,
    output logic [7:0]     grant_cnt1
`endif
);

    arb_state_e     state_q, state_d;
    logic           last_id_q, last_id_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    alu_op_e        op_q, op_d;
    logic           id_q, id_d;
    logic           res_valid_q, res_valid_d;
    logic [2*W-1:0] res_data_q, res_data_d;
    logic           res_id_q, res_id_d;
    logic           gnt0, gnt1;
    logic [2*W-1:0] unit_r;

    alu_logic_unit #(.W(W)) u_unit (
        .a_i  (a_q),
        .b_i  (b_q),
        .op_i (op_q),
        .r_o  (unit_r)
    );

    // Arbitration, operand capture and response sequencing.
    always_comb begin
        state_d     = state_q;
        last_id_d   = last_id_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        id_d        = id_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        case (state_q)
            IDLE: begin
                // Requester 0 wins unless requester 1 is waiting and 0 was served last.
                if (req0_valid && (!req1_valid || last_id_q)) begin
                    gnt0    = 1'b1;
                    a_d     = req0_a;
                    b_d     = req0_b;
                    op_d    = alu_op_e'(req0_op);
                    id_d    = 1'b0;
                    state_d = EXEC;
                end else if (req1_valid) begin
                    gnt1    = 1'b1;
                    a_d     = req1_a;
                    b_d     = req1_b;
                    op_d    = alu_op_e'(req1_op);
                    id_d    = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                res_data_d  = unit_r;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (res_ready) begin
                    last_id_d   = res_id_q;
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset outranks a grant that would otherwise be visible this cycle.
    assign req0_ready = gnt0 & ~rst;
    assign req1_ready = gnt1 & ~rst;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_id     = res_id_q;

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_id_q   <= 1'b1;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_AND;
            id_q        <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_id_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_id_q   <= last_id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            id_q        <= id_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [7:0] cnt0_q, cnt1_q;

    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (gnt0) cnt0_q <= sat_inc8(cnt0_q);
            if (gnt1) cnt1_q <= sat_inc8(cnt1_q);
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_logic_arbiter.sv
// Self-checking bench for alu_logic_arbiter: vector table, NAND sweep, contention, backpressure, reset.
// Latency: checks 2-cycle accept-to-valid through a scoreboard.
// Backpressure: exercises res_ready low in RESP; stats checks compile in with ALU_ARB_STATS_EN.
module tb_alu_logic_arbiter;
    import alu_logic_pkg::*;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]   req0_op, req1_op;
    logic         res_valid, res_ready, res_id;
    logic [7:0]   res_data;
`ifdef ALU_ARB_STATS_EN
    logic [7:0]   grant_cnt0, grant_cnt1;
`endif

    always #5 clk = ~clk;

    alu_logic_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_id     (res_id)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int gseen0 = 0;
    int gseen1 = 0;

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic       id;
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[16];

    logic       prev_valid, prev_ready, prev_id;
    logic [7:0] prev_data;

    function automatic logic [7:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        case (op)
            3'd0: r = a & b;
            3'd1: r = ~(a & b);
            3'd2: r = a | b;
            3'd3: r = ~(a | b);
            3'd4: r = a ^ b;
            3'd5: r = ~(a ^ b);
            3'd6: r = ~a;
            default: r = a;
        endcase
        return {4'h0, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard and protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            sb.delete();
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            gseen0 = 0;
            gseen1 = 0;
        end else begin
            if (req0_ready || req1_ready) begin
                check("grant_onehot", 32'({req0_ready, req1_ready} == 2'b11), 32'd0);
                check("ready_outside_idle", 32'(res_valid), 32'd0);
            end
            if (req0_ready) begin
                check("ready0_without_valid", 32'(req0_valid), 32'd1);
                e.id = 1'b0; e.data = model(req0_op, req0_a, req0_b); e.cyc = cyc;
                sb.push_back(e);
                gseen0++;
            end
            if (req1_ready) begin
                check("ready1_without_valid", 32'(req1_valid), 32'd1);
                e.id = 1'b1; e.data = model(req1_op, req1_a, req1_b); e.cyc = cyc;
                sb.push_back(e);
                gseen1++;
            end
            if (prev_valid && !prev_ready) begin
                check("hold_valid", 32'(res_valid), 32'd1);
                check("hold_data", 32'(res_data), 32'(prev_data));
                check("hold_id", 32'(res_id), 32'(prev_id));
            end
            if (res_valid && !prev_valid) begin
                check("result_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("latency", 32'(cyc - sb[0].cyc), 32'd2);
            end
            if (res_valid && res_ready && sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_data", 32'(res_data), 32'(e.data));
                check("sb_id", 32'(res_id), 32'(e.id));
            end
            prev_valid = res_valid;
            prev_ready = res_ready;
            prev_data  = res_data;
            prev_id    = res_id;
        end
    end

    task automatic drive_req(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    task automatic wait_ready(input logic id, input string name);
        bit got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 32'(got), 32'd1);
    endtask

    task automatic wait_res(input string name);
        bit got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
        end
        check(name, 32'(got), 32'd1);
    endtask

    // One complete transaction with res_ready held high.
    task automatic run_req(input logic id, input logic [2:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [7:0] exp);
        @(posedge clk); #1;
        drive_req(id, op, a, b);
        wait_ready(id, "grant_timeout");
        @(posedge clk); #1;
        if (id == 1'b0) req0_valid = 1'b0; else req1_valid = 1'b0;
        wait_res("result_timeout");
        check("vec_data", 32'(res_data), 32'(exp));
        check("vec_id", 32'(res_id), 32'(id));
        @(posedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int gid[$];
        int gcy[$];

        tbl[0]  = '{1'b0, 3'd0, 4'hA, 4'h6, 8'h02};
        tbl[1]  = '{1'b1, 3'd0, 4'h3, 4'h5, 8'h01};
        tbl[2]  = '{1'b0, 3'd1, 4'hA, 4'h6, 8'h0D};
        tbl[3]  = '{1'b1, 3'd1, 4'h3, 4'h5, 8'h0E};
        tbl[4]  = '{1'b0, 3'd2, 4'hA, 4'h6, 8'h0E};
        tbl[5]  = '{1'b1, 3'd2, 4'h3, 4'h5, 8'h07};
        tbl[6]  = '{1'b0, 3'd3, 4'hA, 4'h6, 8'h01};
        tbl[7]  = '{1'b1, 3'd3, 4'h3, 4'h5, 8'h08};
        tbl[8]  = '{1'b0, 3'd4, 4'hA, 4'h6, 8'h0C};
        tbl[9]  = '{1'b1, 3'd4, 4'h3, 4'h5, 8'h06};
        tbl[10] = '{1'b0, 3'd5, 4'hA, 4'h6, 8'h03};
        tbl[11] = '{1'b1, 3'd5, 4'h3, 4'h5, 8'h09};
        tbl[12] = '{1'b0, 3'd6, 4'hA, 4'h6, 8'h05};
        tbl[13] = '{1'b1, 3'd6, 4'h3, 4'h5, 8'h0C};
        tbl[14] = '{1'b0, 3'd7, 4'hA, 4'h6, 8'h0A};
        tbl[15] = '{1'b1, 3'd7, 4'h3, 4'h5, 8'h03};

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_op = '0;
        req1_a = '0; req1_b = '0; req1_op = '0;

        // Reset values, and reset masking a valid request.
        repeat (3) @(posedge clk);
        #1 req0_valid = 1'b1;
        @(negedge clk);
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; req0_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ready0", 32'(req0_ready), 32'd0);
        check("idle_ready1", 32'(req1_ready), 32'd0);
        check("idle_res_valid", 32'(res_valid), 32'd0);

        // Every op from both requesters; table ends on requester 1.
        res_ready = 1'b1;
        for (int i = 0; i < 16; i++)
            run_req(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);

        // Contention: both valid continuously, grants alternate every 3 cycles.
        @(posedge clk); #1;
        drive_req(1'b0, 3'd4, 4'h3, 4'h5);
        drive_req(1'b1, 3'd2, 4'h3, 4'h5);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (req0_ready) begin gid.push_back(0); gcy.push_back(c); end
            if (req1_ready) begin gid.push_back(1); gcy.push_back(c); end
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        check("cont_grants", 32'(gid.size()), 32'd4);
        if (gid.size() == 4) begin
            check("cont_first_cycle", 32'(gcy[0]), 32'd0);
            for (int i = 0; i < 4; i++) begin
                check("cont_order", 32'(gid[i]), 32'(i % 2));
                if (i > 0) check("cont_spacing", 32'(gcy[i] - gcy[i-1]), 32'd3);
            end
        end
        repeat (4) @(posedge clk);

        // NAND sweep over every operand pair.
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                run_req(1'b0, 3'd1, 4'(a), 4'(b), {4'h0, ~(4'(a) & 4'(b))});

        // Backpressure in RESP with requester 1 waiting.
        @(posedge clk); #1;
        res_ready = 1'b0;
        drive_req(1'b0, 3'd0, 4'hF, 4'h9);
        wait_ready(1'b0, "bp_grant_timeout");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drive_req(1'b1, 3'd7, 4'h7, 4'h0);
        wait_res("bp_result_timeout");
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_valid", 32'(res_valid), 32'd1);
            check("bp_data", 32'(res_data), 32'h09);
            check("bp_id", 32'(res_id), 32'd0);
            check("bp_no_ready1", 32'(req1_ready), 32'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(negedge clk);
        check("bp_no_grant_on_retire", 32'(req1_ready), 32'd0);
        @(negedge clk);
        check("bp_dropped_valid", 32'(res_valid), 32'd0);
        check("bp_grant_after_retire", 32'(req1_ready), 32'd1);
        @(posedge clk); #1;
        req1_valid = 1'b0;
        wait_res("bp_next_timeout");
        check("bp_next_data", 32'(res_data), 32'h07);
        check("bp_next_id", 32'(res_id), 32'd1);
        @(posedge clk);
        run_req(1'b0, 3'd2, 4'h1, 4'h2, 8'h03);

        // Reset during EXEC: abandoned, then requester 0 wins first again.
        @(posedge clk); #1;
        drive_req(1'b0, 3'd4, 4'h1, 4'h2);
        wait_ready(1'b0, "rst_mid_grant_timeout");
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive_req(1'b0, 3'd6, 4'h5, 4'h0);
        drive_req(1'b1, 3'd0, 4'hF, 4'hF);
        @(negedge clk);
        check("rst_mid_res_valid", 32'(res_valid), 32'd0);
        check("rst_mid_res_data", 32'(res_data), 32'd0);
        check("rst_mid_grant0", 32'(req0_ready), 32'd1);
        check("rst_mid_no_grant1", 32'(req1_ready), 32'd0);
        @(posedge clk); #1;
        req0_valid = 1'b0;
        wait_ready(1'b1, "rst_mid_grant1_timeout");
        @(posedge clk); #1;
        req1_valid = 1'b0;
        repeat (5) @(posedge clk);

`ifdef ALU_ARB_STATS_EN
        // Saturating grant counters.
        for (int i = 0; i < 300; i++)
            run_req(1'b0, 3'd7, 4'(i), 4'h0, {4'h0, 4'(i)});
        for (int i = 0; i < 3; i++)
            run_req(1'b1, 3'd6, 4'(i), 4'h0, {4'h0, ~4'(i)});
        @(negedge clk);
        check("grant_cnt0_sat", 32'(grant_cnt0), 32'd255);
        check("grant_cnt1", 32'(grant_cnt1), 32'(gseen1));
`endif

        repeat (3) @(posedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_logic_arbiter.md
# alu_logic_arbiter

Shares one 4-bit logic unit (AND/NAND/OR/NOR/XOR/XNOR/NOT/PASS) between two requesters. Round-robin arbitration, valid/ready handshakes, registered execution and a held response. Results are zero-extended to 8 bits with the upper nibble forced to 0, matching the existing gate datapath. Sits between the requester front ends and the shared logic datapath.

## Interface
- `W`, 4, operand width; result width is `2*W`.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1 — request present.
- `req0_ready`, `req1_ready` out 1 — request accepted this cycle.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in W — operands.
- `req0_op`, `req1_op` in 3 — op code, encoded in `alu_logic_pkg`.
- `res_valid` out 1 — result held.
- `res_ready` in 1 — consumer takes the result.
- `res_data` out 2*W — `{W'b0, r}`.
- `res_id` out 1 — requester that owns `res_data`.
- `grant_cnt0`, `grant_cnt1` out 8 — present only with `ALU_ARB_STATS_EN`.

## Operation
- Op codes:
  - 000 AND, 001 NAND, 010 OR, 011 NOR
  - 100 XOR, 101 XNOR, 110 NOT A, 111 PASS A
- FSM states IDLE, EXEC, RESP.
- **IDLE:**
  - With no valid request, stay in IDLE.
  - With a single valid request, grant it.
  - With both valid, grant the requester not served last. `last_id` resets to 1, so requester 0 wins first.
  - On grant, `reqN_ready` = 1 combinationally for that cycle only. Latch a, b, op and id, then go to EXEC.
- **EXEC:** register the logic-unit output into `res_data` with upper W bits = 0. Set `res_id`, assert `res_valid`, go to RESP.
- **RESP:**
  - Hold `res_valid`, `res_data` and `res_id` stable until `res_ready`.
  - On `res_valid && res_ready`: `last_id <= res_id`, `res_valid` drops next cycle, go to IDLE.
- `req*_ready` is 0 in EXEC and RESP. Requests stay pending and must be held stable by the requester.
- Ungranted valid requests are never dropped.
- Unused op bits do not exist; all 8 codes are defined.

## Timing
- Reset values:
  - state = IDLE, `last_id` = 1
  - `res_valid` = 0, `res_data` = 0, `res_id` = 0
  - `req*_ready` = 0
  - stats counters = 0
- Latency: request accepted at edge N gives `res_valid` = 1 after edge N+1, i.e. 2 cycles from the accept cycle.
- Back-to-back throughput: 1 result per 3 cycles when `res_ready` is held high.
- Simultaneous valid from both requesters: alternate grants 0, 1, 0, 1.
- `res_ready` high in IDLE or EXEC is ignored.
- A new request is not granted in the same cycle the response retires; it is granted on the next IDLE cycle.
- `rst` mid-operation:
  - Abandon the latched request and return to IDLE.
  - The lost request is not replayed; the requester resubmits it.
- `rst` has priority over every other input in the same cycle.

## Configuration
- `ALU_ARB_STATS_EN`:
  - **Defined:** `grant_cnt0` and `grant_cnt1` exist. Each increments on its requester's grant and saturates at 255.
  - **Undefined:** the ports and counters are absent and behaviour is otherwise identical.

## Structure
- Package `alu_logic_pkg` holds:
  - enum `alu_op_e` (3-bit codes above)
  - enum `arb_state_e` (IDLE/EXEC/RESP)
  - localparam `DEF_W` = 4
- Sub-module `alu_logic_unit`: combinational, inputs (a, b, op), output 2*W zero-extended. Instantiated once and fed from the latched operands.
- Arbiter, FSM and counters live in `alu_logic_arbiter`.

## Test plan
1. Reset, then idle → all outputs 0, no ready asserted.
2. Sweep:
   - Stimulus: `req0` only, op NAND, a = 4'hA, b = 4'h6.
   - Response: `req0_ready` pulses 1 cycle; 2 cycles later `res_data` = 8'h0D, `res_id` = 0.
   - Sweep all 256 (a, b) pairs for NAND against `{4'b0, ~(a&b)}`.
3. Contention:
   - Stimulus: both valid continuously, `res_ready` = 1; `req0` op XOR 3^5, `req1` op OR 3|5.
   - Response: grants alternate 0, 1, 0; results 8'h06 (id 0) and 8'h07 (id 1), repeating every 3 cycles.
4. Backpressure: `res_ready` = 0 for 5 cycles in RESP → `res_data` and `res_id` stable, no new `req*_ready`. Raise `res_ready` → retire, then grant the next request.
5. Reset mid-operation: assert `rst` during EXEC → next cycle IDLE, `res_valid` = 0. With both requesters valid afterwards, `req0` is granted first.
6. With `ALU_ARB_STATS_EN`:
   - 300 grants to `req0` → `grant_cnt0` = 255 (saturated).
   - `grant_cnt1` matches its own grant count.
